// File: rtl/pixel_out_stream.sv
// Output stage of the blur pipeline: re-emits the valid-only pixel stream as valid/ready
// through a small FWFT buffer with a registered head, an almost-full throttle and frame-last tagging.
module pixel_out_stream #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 32,
  parameter int AF_THRESH    = 24,
  parameter int FRAME_PIXELS = 262144
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_data_valid,
  output logic                       o_almost_full,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_data_valid,
  input  logic                       i_data_ready,
  output logic                       o_data_last,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FRAME_PIXELS);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_PIXELS - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d, mem_cnt;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  vld_q, vld_d, ovf_q, ovf_d;
  logic [CW-1:0]         pix_cnt_q, pix_cnt_d;
  logic                  wr_acc, pop, load, last;

  // level_q counts the head register too, so the memory holds level_q - vld_q pixels.
  always_comb begin
    wr_acc    = i_data_valid && (level_q < FULL_LVL);
    pop       = vld_q && i_data_ready;
    mem_cnt   = level_q - LW'(vld_q);
    load      = (mem_cnt != '0) && (!vld_q || pop);
    last      = vld_q && (pix_cnt_q == LAST_CNT);
    wr_ptr_d  = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = load ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q + LW'(wr_acc) - LW'(pop);
    vld_d     = load || (vld_q && !pop);
    data_d    = load ? mem_q[rd_ptr_q] : data_q;
    ovf_d     = ovf_q || (i_data_valid && !wr_acc);
    pix_cnt_d = pix_cnt_q;
    if (pop) begin
      pix_cnt_d = last ? '0 : pix_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      ovf_q     <= 1'b0;
      pix_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      ovf_q     <= ovf_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  assign o_data        = data_q;
  assign o_data_valid  = vld_q;
  assign o_data_last   = last;
  assign o_level       = level_q;
  assign o_almost_full = (level_q >= AF_LVL);
  assign o_overflow    = ovf_q;
endmodule
